// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared constants for the CNN inference datapath.
//   CNN_DATA_WIDTH / CNN_FRAC_BITS : default logit word format, Q(FRAC_BITS)
//   CNN_OUT_DIM                    : default number of output classes
//   S_MAX / S_MIN                  : saturation limits of a CNN_DATA_WIDTH word
//   cls_width()                    : class-index width, never below one bit
// ---------------------------------------------------------------------------
package cnn_pkg;

   localparam int CNN_DATA_WIDTH = 16;
   localparam int CNN_FRAC_BITS  = 8;
   localparam int CNN_OUT_DIM    = 10;

   localparam logic signed [CNN_DATA_WIDTH-1:0] S_MAX = {1'b0, {(CNN_DATA_WIDTH-1){1'b1}}};
   localparam logic signed [CNN_DATA_WIDTH-1:0] S_MIN = {1'b1, {(CNN_DATA_WIDTH-1){1'b0}}};

   // A single class still needs a one-bit index.
   function automatic int cls_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dense_readout_if.sv
// ---------------------------------------------------------------------------
// dense_readout_if
// Ready/valid stream carrying one logit per word from the readout block.
//   m_valid : word valid (driven by master)
//   m_ready : sink accepts the word (driven by slave)
//   m_data  : signed logit
//   m_index : class index of m_data
//   m_last  : final word of the vector
// ---------------------------------------------------------------------------
interface dense_readout_if
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int CLS_W      = cls_width(CNN_OUT_DIM)
);

   logic                         m_valid;
   logic                         m_ready;
   logic signed [DATA_WIDTH-1:0] m_data;
   logic [CLS_W-1:0]             m_index;
   logic                         m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_index,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_index,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/dense_readout.sv
// ---------------------------------------------------------------------------
// dense_readout
// Snapshots the dense layer's output vector on start, streams it one logit
// per handshake over a ready/valid interface, and tracks the argmax along the
// way. The winning class and its value are published when the pass finishes.
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset
//   start     : one-cycle pulse from the dense layer (ignored unless idle)
//   in_vec    : OUT_DIM signed logits, captured on start
//   m_if      : stream master (m_valid/m_ready/m_data/m_index/m_last)
//   class_idx : argmax of the last completed pass
//   class_val : logit at class_idx
//   busy      : high whenever a pass is in progress
//   done      : one-cycle pulse at pass completion
// ---------------------------------------------------------------------------
module dense_readout
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int OUT_DIM    = CNN_OUT_DIM,
   parameter int CLS_W      = cls_width(OUT_DIM)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] in_vec [0:OUT_DIM-1],
   dense_readout_if.master              m_if,
   output logic [CLS_W-1:0]             class_idx,
   output logic signed [DATA_WIDTH-1:0] class_val,
   output logic                         busy,
   output logic                         done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_FINISH
   } state_t;

   localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(OUT_DIM - 1);

   state_t                       state_q;
   logic [CLS_W-1:0]             idx_q;
   logic                         valid_q;
   logic                         busy_q;
   logic                         done_q;
   logic signed [DATA_WIDTH-1:0] buf_q [0:OUT_DIM-1];
   logic signed [DATA_WIDTH-1:0] best_val_q;
   logic [CLS_W-1:0]             best_idx_q;
   logic signed [DATA_WIDTH-1:0] class_val_q;
   logic [CLS_W-1:0]             class_idx_q;

   logic signed [DATA_WIDTH-1:0] cur_val;
   logic                         hs;
   logic                         take;
   logic signed [DATA_WIDTH-1:0] best_val_d;
   logic [CLS_W-1:0]             best_idx_d;

   // Single comparator: the current word against the running best. Index 0
   // always seeds the best; a strict '>' keeps the lowest index on ties.
   assign cur_val    = buf_q[idx_q];
   assign hs         = valid_q & m_if.m_ready;
   assign take       = (idx_q == '0) || (cur_val > best_val_q);
   assign best_val_d = take ? cur_val : best_val_q;
   assign best_idx_d = take ? idx_q   : best_idx_q;

   // Snapshot buffer: data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && start) begin
         buf_q <= in_vec;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         best_val_q  <= '0;
         best_idx_q  <= '0;
         class_val_q <= '0;
         class_idx_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= ST_STREAM;
                  idx_q   <= '0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ST_STREAM: begin
               if (hs) begin
                  best_val_q <= best_val_d;
                  best_idx_q <= best_idx_d;
                  if (idx_q == LAST_IDX) begin
                     // Result includes the final word via the _d values.
                     state_q     <= ST_FINISH;
                     valid_q     <= 1'b0;
                     done_q      <= 1'b1;
                     class_val_q <= best_val_d;
                     class_idx_q <= best_idx_d;
                  end else begin
                     idx_q <= idx_q + CLS_W'(1);
                  end
               end
            end
            ST_FINISH: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Stream outputs decode from registered state only; m_ready never
   // reaches them combinationally, so a stalled word holds by construction.
   assign m_if.m_valid = valid_q;
   assign m_if.m_data  = cur_val;
   assign m_if.m_index = idx_q;
   assign m_if.m_last  = valid_q && (idx_q == LAST_IDX);

   assign class_idx = class_idx_q;
   assign class_val = class_val_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: doc/dense_readout.md
DENSE_READOUT -- requirements
Module: dense_readout

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed logit word width, Q(FRAC_BITS) from the dense layer, not reinterpreted here.
REQ-002 Parameter OUT_DIM, default 10: number of logits/classes; legal range 1..256.
REQ-003 Derived CLS_W = max(1, $clog2(OUT_DIM)): class index width.
REQ-004 clk  in  1  rising-edge clock; the block's only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; connected to the dense layer's done.
REQ-007 in_vec  in  [0:OUT_DIM-1] x DATA_WIDTH signed  dense output vector.
REQ-008 m_valid  out  1  stream word valid.
REQ-009 m_ready  in  1  downstream accepts the word.
REQ-010 m_data  out  DATA_WIDTH signed  current logit.
REQ-011 m_index  out  CLS_W  index of m_data.
REQ-012 m_last  out  1  high with the final word (index OUT_DIM-1).
REQ-013 class_idx  out  CLS_W  argmax of the last completed pass.
REQ-014 class_val  out  DATA_WIDTH signed  logit value at class_idx.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse at pass completion.

Function
REQ-017 FSM states: IDLE, STREAM, FINISH.
REQ-018 IDLE with start=1: snapshot all of in_vec into an internal buffer, set idx=0, go to STREAM.
REQ-019 In IDLE, start=0 keeps the FSM in IDLE.
REQ-020 start is ignored outside IDLE. After the snapshot, changes on in_vec have no effect on the pass.
REQ-021 STREAM: m_valid=1, m_data=buf[idx], m_index=idx, m_last=(idx==OUT_DIM-1).
REQ-022 m_valid, m_data, m_index and m_last decode only from registered state, idx and buffer; there is no combinational path from m_ready.
REQ-023 Handshake occurs when m_valid and m_ready are both high.
REQ-024 While m_valid is high and m_ready is low, m_data, m_index and m_last hold stable.
REQ-025 On each handshake, best_val/best_idx load buf[idx]/idx when idx==0 or buf[idx] > best_val (signed, strict compare). Ties keep the lowest index.
REQ-026 A handshake at idx==OUT_DIM-1: go to FINISH and load class_idx/class_val from the final best (including this word). Otherwise idx increments.
REQ-027 FINISH: done=1 for exactly one cycle, then return to IDLE.
REQ-028 class_idx and class_val hold their values until the next pass completes.
REQ-029 Latency with m_ready held high: start in cycle 0, first m_valid in cycle 1, m_last handshake in cycle OUT_DIM, done in cycle OUT_DIM+1.
REQ-030 OUT_DIM=1: one word with m_last=1, then FINISH.

Reset
REQ-031 Reset forces state=IDLE and idx=0. m_valid, busy and done are 0. class_idx=0, class_val=0. best_idx=0, best_val=0.
REQ-032 The snapshot buffer needs no reset value.
REQ-033 Reset asserted mid-pass aborts the pass: outputs take reset values on the next edge, and no done pulse is issued.
REQ-034 Reset and start in the same cycle: reset wins.

Structure
REQ-035 The shared package cnn_pkg holds the default DATA_WIDTH, FRAC_BITS and OUT_DIM and the S_MAX/S_MIN saturation constants.
REQ-036 The readout state typedef is local to dense_readout.
REQ-037 No sub-module: the argmax comparator and the buffer are inline, with a single compare per cycle.

Verification
REQ-038 in_vec={5,-3,128,7,128,0,-200,64,1,2}, m_ready=1, start at cycle 0 -> words 0..9 in order in cycles 1..10, m_last on index 9, class_idx=2, class_val=128, done in cycle 11.
REQ-039 Same vector, m_ready alternating 0/1 starting at 0 -> each word holds stable across its stall cycle, 10 handshakes, done in cycle 21, class_idx=2.
REQ-040 All logits -32768 -> class_idx=0, class_val=-32768. Separate run with logit[9]=32767 and all others 0 -> class_idx=9, class_val=32767.
REQ-041 Second start pulse at cycle 4 and in_vec overwritten with zeros at cycle 2 -> no restart, and streamed data and result match the original snapshot.
REQ-042 Reset at cycle 5 of a pass -> m_valid=0 and busy=0 from cycle 6, no done, class_idx=0; a new start afterwards completes normally.
